// File: rtl/vga_timing_pkg.sv
// Shared 640x480 timing defaults, lock-state encoding and counter helpers
// used by the VGA stream generator and its receive-side decoder.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam logic DEF_SYNC_ACTIVE = 1'b0;

  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

  // Counters stick at all-ones so a dead sync input cannot wrap back into range.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop sampler for one sync line, flagging the cycle where the sampled
// level first turns active.
module sync_edge_det
  import vga_timing_pkg::*;
#(
  parameter logic ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lead
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= ~ACTIVE;
      s2 <= ~ACTIVE;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign lead = (s1 == ACTIVE) && (s2 != ACTIVE);

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel position, active video and frame starts from a sampled VGA
// stream and checks line/frame geometry, reporting lock and violations.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_FRONT     = DEF_H_FRONT,
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BACK      = DEF_H_BACK,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_FRONT     = DEF_V_FRONT,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BACK      = DEF_V_BACK,
  parameter logic SYNC_ACTIVE = DEF_SYNC_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [29:0] rgb_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic [29:0] rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt,
  output lock_state_t state
);

  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_SYNC + V_BACK + V_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             h_lead;
  logic             v_lead;
  logic [29:0]      rgb_s1;
  logic [29:0]      rgb_s2;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] vcnt;
  logic             vs_pend;
  logic             seen_h;
  logic             seen_v;
  logic             err_s2;
  lock_state_t      fsm_state;

  logic v_clear;
  logic line_err;
  logic frame_err;
  logic timeout;
  logic any_err;
  logic h_act;
  logic v_act;
  logic active;

  sync_edge_det #(.ACTIVE(SYNC_ACTIVE)) u_hs_det (
    .clk  (clk),
    .rst  (rst),
    .d    (hsync),
    .lead (h_lead)
  );

  sync_edge_det #(.ACTIVE(SYNC_ACTIVE)) u_vs_det (
    .clk  (clk),
    .rst  (rst),
    .d    (vsync),
    .lead (v_lead)
  );

  // A vsync edge arms the line counter clear; it fires on the next hsync edge,
  // or immediately when both edges land together.
  assign v_clear   = h_lead && (vs_pend || v_lead);
  assign line_err  = h_lead && seen_h && (hcnt != H_END);
  assign frame_err = v_clear && seen_v && (vcnt != V_END);
  assign timeout   = !h_lead && (hcnt == CNT_MAX - 1'b1);
  assign any_err   = line_err || frame_err || timeout;

  assign h_act  = (hcnt >= H_FIRST) && (hcnt <= H_LAST);
  assign v_act  = (vcnt >= V_FIRST) && (vcnt <= V_LAST);
  assign active = h_act && v_act;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_s1  <= '0;
      rgb_s2  <= '0;
      hcnt    <= '0;
      vcnt    <= '0;
      vs_pend <= 1'b0;
      seen_h  <= 1'b0;
      seen_v  <= 1'b0;
      err_s2  <= 1'b0;
    end else begin
      rgb_s1 <= rgb_in;
      rgb_s2 <= rgb_s1;
      hcnt   <= h_lead ? '0 : sat_inc(hcnt);
      if (v_clear) begin
        vcnt <= '0;
      end else if (h_lead) begin
        vcnt <= sat_inc(vcnt);
      end
      if (v_clear) begin
        vs_pend <= 1'b0;
      end else if (v_lead) begin
        vs_pend <= 1'b1;
      end
      seen_h <= seen_h | h_lead;
      seen_v <= seen_v | v_clear;
      err_s2 <= any_err;
    end
  end

  // An error in the same cycle as a frame boundary wins over advancing the lock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_state <= UNLOCKED;
    end else begin
      case (fsm_state)
        UNLOCKED: if (!any_err && v_clear) fsm_state <= ACQUIRE;
        ACQUIRE: begin
          if (any_err) begin
            fsm_state <= UNLOCKED;
          end else if (v_clear) begin
            fsm_state <= LOCKED;
          end
        end
        LOCKED:   if (any_err) fsm_state <= UNLOCKED;
        default:  fsm_state <= UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      err         <= 1'b0;
      err_cnt     <= '0;
      state       <= UNLOCKED;
    end else begin
      de          <= active;
      x           <= active ? hcnt - H_FIRST : '0;
      y           <= v_act ? vcnt - V_FIRST : '0;
      rgb_out     <= active ? rgb_s2 : '0;
      frame_start <= active && (hcnt == H_FIRST) && (vcnt == V_FIRST) && (fsm_state == LOCKED);
      locked      <= (fsm_state == LOCKED);
      state       <= fsm_state;
      err         <= err_s2;
      if (err_s2 && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Stream-level bench for vga_sync_decoder on a shrunken raster so full frames
// stay short; expected outputs come from the bench's own view of the stream.
module tb_vga_sync_decoder;
  import vga_timing_pkg::*;

  localparam int HA = 16;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam logic SA = 1'b0;
  localparam int CMAX = 2047;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync;
  logic        vsync;
  logic [29:0] rgb_in;
  logic [10:0] x;
  logic [10:0] y;
  logic        de;
  logic [29:0] rgb_out;
  logic        frame_start;
  logic        locked;
  logic        err;
  logic [7:0]  err_cnt;
  lock_state_t state;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
    .x(x), .y(y), .de(de), .rgb_out(rgb_out), .frame_start(frame_start),
    .locked(locked), .err(err), .err_cnt(err_cnt), .state(state)
  );

  int checks = 0;
  int errors = 0;

  // {pix_ok, state, locked, err, err_cnt, de, x, y, rgb_out, frame_start}
  logic [66:0] exp_q[$];

  bit       push_en;
  bit       seen_h;
  bit       seen_v;
  bit       pix_ok;
  int       line_len;
  int       lines;
  int       lock_clears;
  logic [7:0] exp_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    seen_h      = 1'b0;
    seen_v      = 1'b0;
    pix_ok      = 1'b0;
    line_len    = 0;
    lines       = 0;
    lock_clears = 0;
    exp_cnt     = 8'd0;
  endtask

  // One stream cycle: check the output due now, drive the next sample, and
  // queue what that sample must produce three cycles later.
  task automatic step(input logic hs, input logic vs, input bit hedge, input bit vclear);
    logic [66:0] e;
    logic [29:0] rgb;
    logic [10:0] ex;
    logic [10:0] ey;
    bit le, fe, te, terr, hact, vact, dact, efs;
    int hc, vc;
    lock_state_t est;
    @(negedge clk);
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check("stat", 64'({state, locked, err, err_cnt}), 64'(e[65:54]));
      if (e[66]) check("pix", 64'({de, x, y, rgb_out, frame_start}), 64'(e[53:0]));
    end
    rgb    = 30'($urandom);
    hsync  = hs;
    vsync  = vs;
    rgb_in = rgb;
    if (!push_en) return;
    le = 1'b0;
    fe = 1'b0;
    te = 1'b0;
    if (hedge) begin
      le       = seen_h && (line_len != HT);
      seen_h   = 1'b1;
      line_len = 1;
      if (vclear) begin
        fe     = seen_v && (lines != VT);
        seen_v = 1'b1;
        lines  = 1;
        pix_ok = 1'b1;
      end else begin
        lines++;
      end
    end else begin
      line_len++;
      te = (line_len - 1 == CMAX);
    end
    terr = le || fe || te;
    if (terr) lock_clears = 0;
    else if (vclear && lock_clears < 2) lock_clears++;
    if (terr && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    hc   = (line_len - 1 > CMAX) ? CMAX : line_len - 1;
    vc   = (lines - 1 > CMAX) ? CMAX : lines - 1;
    hact = (hc >= HS + HB) && (hc <= HS + HB + HA - 1);
    vact = (vc >= VS + VB) && (vc <= VS + VB + VA - 1);
    dact = hact && vact;
    ex   = dact ? 11'(hc - (HS + HB)) : 11'd0;
    ey   = vact ? 11'(vc - (VS + VB)) : 11'd0;
    efs  = dact && (hc == HS + HB) && (vc == VS + VB) && (lock_clears == 2);
    est  = (lock_clears == 2) ? LOCKED : (lock_clears == 1) ? ACQUIRE : UNLOCKED;
    exp_q.push_back({pix_ok, est, lock_clears == 2, terr, exp_cnt,
                     dact, ex, ey, dact ? rgb : 30'd0, efs});
  endtask

  task automatic line_px(input int h, input int vline);
    logic hs, vs;
    hs = (h < HS) ? SA : ~SA;
    vs = (vline < VS) ? SA : ~SA;
    step(hs, vs, h == 0, (h == 0) && (vline == 0));
  endtask

  task automatic run_line(input int len, input int vline);
    for (int h = 0; h < len; h++) line_px(h, vline);
  endtask

  task automatic run_frame(input int nlines, input int short_line);
    for (int l = 0; l < nlines; l++) run_line((l == short_line) ? HT - 1 : HT, l);
  endtask

  initial begin
    rst    = 1'b0;
    hsync  = ~SA;
    vsync  = ~SA;
    rgb_in = '0;
    push_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_pix", 64'({de, x, y, rgb_out, frame_start}), 64'(0));
    check("rst_stat", 64'({state, locked, err, err_cnt}), 64'(0));
    rst     = 1'b1;
    push_en = 1'b1;

    repeat (3) run_frame(VT, -1);
    check("nom_locked", 64'(locked), 64'(1));
    check("nom_cnt", 64'(err_cnt), 64'(0));

    run_frame(VT, 7);
    check("short_locked", 64'(locked), 64'(0));
    check("short_cnt", 64'(err_cnt), 64'(1));
    repeat (3) run_frame(VT, -1);
    check("relock_line", 64'(locked), 64'(1));

    run_frame(VT - 1, -1);
    run_frame(VT, -1);
    check("frame_state", 64'(state), 64'(UNLOCKED));
    check("frame_cnt", 64'(err_cnt), 64'(2));
    repeat (2) run_frame(VT, -1);
    check("relock_frame", 64'(locked), 64'(1));

    repeat (2100) step(~SA, ~SA, 1'b0, 1'b0);
    check("tmo_locked", 64'(locked), 64'(0));
    check("tmo_cnt", 64'(err_cnt), 64'(3));
    repeat (3) run_frame(VT, -1);
    check("relock_tmo", 64'(locked), 64'(1));
    check("resume_cnt", 64'(err_cnt), 64'(4));

    // Reset lands mid-line in the active area; release while hsync is idle.
    for (int l = 0; l < 6; l++) run_line(HT, l);
    for (int h = 0; h < HT; h++) begin
      if (h == 20) push_en = 1'b1;
      line_px(h, 6);
      if (h == 16) begin
        #2 rst = 1'b0;
        #1;
        check("arst_pix", 64'({de, x, y, rgb_out, frame_start}), 64'(0));
        check("arst_stat", 64'({state, locked, err, err_cnt}), 64'(0));
        exp_q.delete();
        push_en = 1'b0;
        model_reset();
      end
      if (h == 20) rst = 1'b1;
    end
    for (int l = 7; l < VT; l++) run_line(HT, l);
    check("post_rst_locked", 64'(locked), 64'(0));
    run_frame(VT, -1);
    check("post_rst_acq", 64'(state), 64'(ACQUIRE));
    check("post_rst_unl", 64'(locked), 64'(0));
    run_frame(VT, -1);
    check("post_rst_lock", 64'(locked), 64'(1));
    check("post_rst_cnt", 64'(err_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
